// File: rtl/gray_sync_decoder.sv
// Gray-code count receiver: synchronises an upstream Gray count, converts it to
// binary and checks that every change is a single +1 step.
module gray_sync_decoder #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 clear_err,
    output logic [WIDTH-1:0]     gray_sync,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 step_valid,
    output logic                 wrap_pulse,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [1:0] ST_ACQUIRE = 2'd0;
    localparam logic [1:0] ST_TRACK   = 2'd1;
    localparam logic [1:0] ST_FAULT   = 2'd2;

    localparam int ACQ_W = $clog2(SYNC_STAGES + 1);
    localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(SYNC_STAGES);

    logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]     bin_d;
    logic [WIDTH-1:0]     bin_q;
    logic [WIDTH-1:0]     bin_prev_d;
    logic [WIDTH-1:0]     bin_prev_q;
    logic [WIDTH-1:0]     delta;
    logic [1:0]           state_d;
    logic [1:0]           state_q;
    logic [ACQ_W-1:0]     acq_d;
    logic [ACQ_W-1:0]     acq_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic                 tracking;
    logic                 legal_step;
    logic                 illegal;
    logic                 load_ref;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign gray_sync = sync_q[SYNC_STAGES-1];

    // Binary bit i is the XOR of all Gray bits from i upwards.
    always_comb begin
        bin_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_d[i] = ^(gray_sync >> i);
        end
    end

    assign delta      = bin_q - bin_prev_q;
    assign tracking   = (state_q == ST_TRACK);
    assign legal_step = (delta == WIDTH'(1));
    assign illegal    = tracking && (delta != '0) && !legal_step;
    assign load_ref   = (state_q == ST_ACQUIRE) && (acq_q == ACQ_LAST);

    always_comb begin
        state_d = state_q;
        acq_d   = acq_q;
        case (state_q)
            ST_ACQUIRE: begin
                if (acq_q == ACQ_LAST) begin
                    state_d = ST_TRACK;
                end else begin
                    acq_d = acq_q + ACQ_W'(1);
                end
            end
            ST_TRACK: begin
                if (illegal) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (clear_err) begin
                    state_d = ST_TRACK;
                end
            end
            default: begin
                state_d = ST_ACQUIRE;
            end
        endcase
    end

    // Leaving ACQUIRE makes the freshly registered value the reference.
    assign bin_prev_d = load_ref ? bin_d : bin_q;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (illegal && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q      <= '0;
            bin_prev_q <= '0;
            state_q    <= ST_ACQUIRE;
            acq_q      <= '0;
            err_cnt_q  <= '0;
        end else begin
            bin_q      <= bin_d;
            bin_prev_q <= bin_prev_d;
            state_q    <= state_d;
            acq_q      <= acq_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bin_out    = bin_q;
    assign step_valid = tracking && legal_step;
    assign wrap_pulse = tracking && legal_step && (&bin_prev_q);
    assign step_err   = (state_q == ST_FAULT);
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Bench for gray_sync_decoder: scoreboard of expected bin_out and pulses,
// plus inline status checks per scenario.
module tb_gray_sync_decoder;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  gray_in = '0;
    logic          clear_err = 1'b0;
    logic [W-1:0]  gray_sync;
    logic [W-1:0]  bin_out;
    logic          step_valid;
    logic          wrap_pulse;
    logic          step_err;
    logic [EW-1:0] err_count;

    typedef struct packed {
        logic [W-1:0] bin;
        logic         sv;
        logic         wr;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    gray_sync_decoder #(
        .WIDTH(W),
        .SYNC_STAGES(S),
        .ERR_CNT_W(EW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .gray_in(gray_in),
        .clear_err(clear_err),
        .gray_sync(gray_sync),
        .bin_out(bin_out),
        .step_valid(step_valid),
        .wrap_pulse(wrap_pulse),
        .step_err(step_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Drive one binary value as Gray and check the entry leaving the pipeline.
    task automatic tick(input logic [W-1:0] b, input logic sv, input logic wr);
        exp_t e;
        exp_t got;
        gray_in = to_gray(b);
        e.bin = b;
        e.sv  = sv;
        e.wr  = wr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        tests_run++;
        if ({bin_out, step_valid, wrap_pulse} !== {got.bin, got.sv, got.wr}) begin
            tests_failed++;
            $display("FAIL scoreboard: got bin=%0d sv=%0b wr=%0b, need bin=%0d sv=%0b wr=%0b",
                     bin_out, step_valid, wrap_pulse, got.bin, got.sv, got.wr);
        end
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0d, need %0d", name, act, req);
        end
    endtask

    task automatic do_reset(input logic [W-1:0] start);
        exp_t z;
        reset     = 1'b1;
        gray_in   = to_gray(start);
        clear_err = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        z = '0;
        repeat (S) exp_q.push_back(z);
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        chk("reset_bin_out", 32'(bin_out), 0);
        chk("reset_gray_sync", 32'(gray_sync), 0);
        chk("reset_step_valid", 32'(step_valid), 0);
        chk("reset_wrap_pulse", 32'(wrap_pulse), 0);
        chk("reset_step_err", 32'(step_err), 0);
        chk("reset_err_count", 32'(err_count), 0);
        @(negedge clk);
    endtask

    task automatic test_increment();
        do_reset(0);
        for (int i = 0; i < 20; i++) begin
            tick(W'(i), (i >= 1), 1'b0);
        end
        chk("inc_gray_sync", 32'(gray_sync), 32'(to_gray(W'(18))));
        chk("inc_step_err", 32'(step_err), 0);
        chk("inc_err_count", 32'(err_count), 0);
    endtask

    task automatic test_single_step();
        do_reset(5);
        repeat (4) tick(5, 1'b0, 1'b0);
        tick(6, 1'b1, 1'b0);
        repeat (3) tick(6, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        do_reset(255);
        repeat (4) tick(255, 1'b0, 1'b0);
        tick(0, 1'b1, 1'b1);
        repeat (2) tick(0, 1'b0, 1'b0);
        tick(1, 1'b1, 1'b0);
        repeat (2) tick(1, 1'b0, 1'b0);
    endtask

    task automatic test_illegal_jump();
        do_reset(6);
        repeat (4) tick(6, 1'b0, 1'b0);
        repeat (3) tick(9, 1'b0, 1'b0);
        chk("jump_err_same_cycle", 32'(step_err), 0);
        tick(9, 1'b0, 1'b0);
        chk("jump_step_err", 32'(step_err), 1);
        chk("jump_err_count", 32'(err_count), 1);
        repeat (4) tick(2, 1'b0, 1'b0);
        repeat (4) tick(9, 1'b0, 1'b0);
        chk("fault_no_recount", 32'(err_count), 1);
        chk("fault_held", 32'(step_err), 1);
    endtask

    task automatic test_clear();
        clear_err = 1'b1;
        tick(9, 1'b0, 1'b0);
        clear_err = 1'b0;
        chk("clear_drops_err", 32'(step_err), 0);
        repeat (3) tick(8, 1'b0, 1'b0);
        chk("backward_err_pending", 32'(step_err), 0);
        tick(8, 1'b0, 1'b0);
        chk("backward_step_err", 32'(step_err), 1);
        chk("backward_err_count", 32'(err_count), 2);
        repeat (3) tick(20, 1'b0, 1'b0);
        clear_err = 1'b1;
        tick(20, 1'b0, 1'b0);
        clear_err = 1'b0;
        chk("clear_wins_err", 32'(step_err), 0);
        chk("clear_wins_count", 32'(err_count), 2);
        tick(21, 1'b1, 1'b0);
        repeat (3) tick(21, 1'b0, 1'b0);
        chk("rearm_no_err", 32'(step_err), 0);
    endtask

    task automatic test_async_reset();
        exp_t z;
        do_reset(40);
        for (int i = 0; i < 10; i++) begin
            tick(W'(40 + i), (i >= 1), 1'b0);
        end
        repeat (4) tick(60, 1'b0, 1'b0);
        chk("pre_reset_err_count", 32'(err_count), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_bin_out", 32'(bin_out), 0);
        chk("async_gray_sync", 32'(gray_sync), 0);
        chk("async_err_count", 32'(err_count), 0);
        chk("async_step_err", 32'(step_err), 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        z = '0;
        repeat (S) exp_q.push_back(z);
        for (int i = 0; i < 6; i++) begin
            tick(W'(61 + i), (i >= 1), 1'b0);
        end
        chk("post_reset_err", 32'(step_err), 0);
    endtask

    initial begin
        test_reset();
        test_increment();
        test_single_step();
        test_wrap();
        test_illegal_jump();
        test_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
